// File: rtl/note_source_arbiter_if.sv
// Request/grant bundle between the song/key sources, the note arbiter and the tone divider.
// master = source side (song shifter, key decoder); slave = arbiter side.
interface note_source_arbiter_if #(
    parameter int NOTE_W = 5
);
    logic              song_valid;
    logic [NOTE_W-1:0] song_note;
    logic              song_ready;
    logic              key_valid;
    logic [NOTE_W-1:0] key_note;
    logic [NOTE_W-1:0] tone_note;
    logic              tone_on;
    logic              grant_key;

    modport master (
        output song_valid, song_note, key_valid, key_note,
        input  song_ready, tone_note, tone_on, grant_key
    );

    modport slave (
        input  song_valid, song_note, key_valid, key_note,
        output song_ready, tone_note, tone_on, grant_key
    );
endinterface

// File: rtl/note_source_arbiter.sv
// Shares one tone generator between the song stream (one note per tempo tick) and live keys.
// Latency: 1 cycle from accepted song note / held key to tone_note/tone_on.
// Backpressure: song_ready only on a tick with no key held in IDLE/SONG; keys are never stalled.
// Optional ILLEGAL_NOTE_CNT_EN adds a saturating illegal_cnt[7:0] counter of out-of-range notes.
module note_source_arbiter #(
    parameter int NOTE_W     = 5,
    parameter int MAX_NOTE   = 21,
    parameter int TICK_DIV   = 6250000,
    parameter int TAIL_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    note_source_arbiter_if.slave bus,
    output logic                 tick_o,
    output logic [1:0]           state_o
`ifdef ILLEGAL_NOTE_CNT_EN
    ,
    output logic [7:0]           illegal_cnt
`endif
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TAIL_W = $clog2(TAIL_TICKS + 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SONG = 2'd1;
    localparam logic [1:0] ST_KEY  = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    logic [TICK_W-1:0] tick_cnt;
    logic [TAIL_W-1:0] tail_cnt;
    logic [1:0]        state;
    logic [NOTE_W-1:0] tone_note_q;
    logic              tone_on_q;
    logic [NOTE_W-1:0] song_san;
    logic [NOTE_W-1:0] key_san;
    logic              song_xfer;

    function automatic logic [NOTE_W-1:0] sanitize(input logic [NOTE_W-1:0] n);
        return (n > NOTE_W'(MAX_NOTE)) ? '0 : n;
    endfunction

    assign song_san = sanitize(bus.song_note);
    assign key_san  = sanitize(bus.key_note);

    assign tick_o         = enable && (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign bus.song_ready = tick_o && !bus.key_valid && (state == ST_IDLE || state == ST_SONG);
    assign song_xfer      = bus.song_valid && bus.song_ready;

    assign bus.tone_note = tone_note_q;
    assign bus.tone_on   = tone_on_q;
    assign bus.grant_key = (state == ST_KEY) || (state == ST_TAIL);
    assign state_o       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (!enable || tick_o)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // A held key overrides every state; the release tick is not counted against the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tail_cnt    <= '0;
            tone_note_q <= '0;
            tone_on_q   <= 1'b0;
        end else if (!enable) begin
            state       <= ST_IDLE;
            tail_cnt    <= '0;
            tone_note_q <= '0;
            tone_on_q   <= 1'b0;
        end else if (bus.key_valid) begin
            state       <= ST_KEY;
            tone_note_q <= key_san;
            tone_on_q   <= |key_san;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (song_xfer) begin
                        state       <= ST_SONG;
                        tone_note_q <= song_san;
                        tone_on_q   <= |song_san;
                    end
                end
                ST_SONG: begin
                    if (song_xfer) begin
                        tone_note_q <= song_san;
                        tone_on_q   <= |song_san;
                    end else if (tick_o) begin
                        state       <= ST_IDLE;
                        tone_note_q <= '0;
                        tone_on_q   <= 1'b0;
                    end
                end
                ST_KEY: begin
                    tone_on_q <= 1'b0;
                    if (TAIL_TICKS == 0) begin
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_TAIL;
                        tail_cnt <= TAIL_W'(TAIL_TICKS);
                    end
                end
                default: begin
                    if (tick_o) begin
                        tail_cnt <= tail_cnt - 1'b1;
                        if (tail_cnt == TAIL_W'(1))
                            state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ILLEGAL_NOTE_CNT_EN
    logic illegal_hit;

    assign illegal_hit = (song_xfer && (bus.song_note > NOTE_W'(MAX_NOTE))) ||
                         ((state == ST_KEY) && bus.key_valid && (bus.key_note > NOTE_W'(MAX_NOTE)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (!enable)
            illegal_cnt <= '0;
        else if (illegal_hit && (illegal_cnt != 8'hFF))
            illegal_cnt <= illegal_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_note_source_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_note_source_arbiter;
    localparam int NOTE_W     = 5;
    localparam int MAX_NOTE   = 21;
    localparam int TICK_DIV   = 4;
    localparam int TAIL_TICKS = 2;

    localparam int M_IDLE = 0;
    localparam int M_SONG = 1;
    localparam int M_KEY  = 2;
    localparam int M_TAIL = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       tick_o;
    logic [1:0] state_o;
`ifdef ILLEGAL_NOTE_CNT_EN
    logic [7:0] illegal_cnt;
`endif

    note_source_arbiter_if #(.NOTE_W(NOTE_W)) bus ();

    note_source_arbiter #(
        .NOTE_W    (NOTE_W),
        .MAX_NOTE  (MAX_NOTE),
        .TICK_DIV  (TICK_DIV),
        .TAIL_TICKS(TAIL_TICKS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus),
        .tick_o (tick_o),
        .state_o(state_o)
`ifdef ILLEGAL_NOTE_CNT_EN
        ,
        .illegal_cnt(illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: mode, enabled-cycle phase within the tempo period, tail ticks left, tone.
    int m_mode  = M_IDLE;
    int m_phase = 0;
    int m_tail  = 0;
    int m_note  = 0;
    int m_on    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int san(input int n);
        return (n > MAX_NOTE) ? 0 : n;
    endfunction

    function automatic int exp_tick();
        return (enable && m_phase == TICK_DIV - 1) ? 1 : 0;
    endfunction

    function automatic int exp_ready();
        return (exp_tick() != 0 && !bus.key_valid && (m_mode == M_IDLE || m_mode == M_SONG)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_tail = 0; m_note = 0; m_on = 0;
    endtask

    task automatic model_step();
        int t;
        int xfer;
        t    = exp_tick();
        xfer = (exp_ready() != 0 && bus.song_valid) ? 1 : 0;
        if (!enable) begin
            model_reset();
        end else begin
            m_phase = (m_phase + 1) % TICK_DIV;
            if (bus.key_valid) begin
                m_mode = M_KEY; m_note = san(int'(bus.key_note)); m_on = (m_note != 0);
            end else if (xfer != 0) begin
                m_mode = M_SONG; m_note = san(int'(bus.song_note)); m_on = (m_note != 0);
            end else if (m_mode == M_SONG && t != 0) begin
                m_mode = M_IDLE; m_note = 0; m_on = 0;
            end else if (m_mode == M_KEY) begin
                m_on = 0;
                if (TAIL_TICKS == 0) m_mode = M_IDLE;
                else begin m_mode = M_TAIL; m_tail = TAIL_TICKS; end
            end else if (m_mode == M_TAIL && t != 0) begin
                m_tail--;
                if (m_tail == 0) m_mode = M_IDLE;
            end
        end
    endtask

    // Called with inputs settled just after a rising edge; returns at the same point one cycle later.
    task automatic cycle();
        @(negedge clk);
        chk("tick_o", tick_o, exp_tick());
        chk("song_ready", bus.song_ready, exp_ready());
        chk("state", state_o, m_mode);
        chk("tone_note", bus.tone_note, m_note);
        chk("tone_on", bus.tone_on, m_on);
        chk("grant_key", bus.grant_key, (m_mode == M_KEY || m_mode == M_TAIL) ? 1 : 0);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic until_tick();
        int k;
        k = 0;
        while (exp_tick() == 0 && k < 4 * TICK_DIV) begin
            cycle();
            k++;
        end
        chk("tick_wait", tick_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.song_valid = 1'b0;
        bus.song_note  = '0;
        bus.key_valid  = 1'b0;
        bus.key_note   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_tone_on", bus.tone_on, 0);
        chk("rst_tone_note", bus.tone_note, 0);
        chk("rst_grant", bus.grant_key, 0);
        chk("rst_tick", tick_o, 0);
        rst_n = 1'b1;
        cycle();

        // Song pacing: one note per tick
        enable = 1'b1;
        bus.song_valid = 1'b1;
        bus.song_note  = 5'd8;
        until_tick(); cycle();
        chk("song_8", bus.tone_note, 8);
        chk("song_state", state_o, 1);
        bus.song_note = 5'd9;
        until_tick(); cycle();
        chk("song_9", bus.tone_note, 9);
        bus.song_note = 5'd10;
        until_tick(); cycle();
        chk("song_10", bus.tone_note, 10);
        chk("song_on", bus.tone_on, 1);

        // Key pre-empts on a tick; pending song note 11 is held back
        bus.song_note = 5'd11;
        until_tick();
        bus.key_valid = 1'b1;
        bus.key_note  = 5'd15;
        cycle();
        chk("key_state", state_o, 2);
        chk("key_grant", bus.grant_key, 1);
        chk("key_note", bus.tone_note, 15);
        repeat (3) cycle();
        bus.key_valid = 1'b0;
        cycle();
        chk("tail_state", state_o, 3);
        chk("tail_on", bus.tone_on, 0);
        until_tick(); cycle();
        chk("tail_mid", state_o, 3);
        until_tick(); cycle();
        chk("tail_done", state_o, 0);
        until_tick(); cycle();
        chk("resume_note", bus.tone_note, 11);
        chk("resume_state", state_o, 1);

        // Out-of-range and rest notes both silence the speaker
        bus.song_note = 5'd27;
        until_tick(); cycle();
        chk("illegal_note", bus.tone_note, 0);
        chk("illegal_on", bus.tone_on, 0);
        bus.song_note = 5'd0;
        until_tick(); cycle();
        chk("rest_on", bus.tone_on, 0);

        // Underrun then recovery
        bus.song_valid = 1'b0;
        until_tick(); cycle();
        chk("underrun_state", state_o, 0);
        bus.song_valid = 1'b1;
        bus.song_note  = 5'd7;
        until_tick(); cycle();
        chk("recover_note", bus.tone_note, 7);
        chk("recover_state", state_o, 1);

        // Asynchronous reset while a key plays
        bus.key_valid = 1'b1;
        bus.key_note  = 5'd3;
        cycle(); cycle();
        chk("prereset_on", bus.tone_on, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_on", bus.tone_on, 0);
        chk("arst_note", bus.tone_note, 0);
        chk("arst_grant", bus.grant_key, 0);
        chk("arst_tick", tick_o, 0);
        chk("arst_ready", bus.song_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Enable drop during the tail restarts the tempo counter
        bus.song_valid = 1'b0;
        cycle();
        bus.key_valid = 1'b0;
        cycle();
        chk("tail_again", state_o, 3);
        enable = 1'b0;
        cycle();
        chk("disable_state", state_o, 0);
        chk("disable_grant", bus.grant_key, 0);
        enable = 1'b1;
        repeat (TICK_DIV - 1) cycle();
        chk("tick_restart", tick_o, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.key_valid = ~bus.key_valid;
            bus.key_note   = NOTE_W'($urandom_range(0, 31));
            bus.song_valid = ($urandom_range(0, 3) != 0);
            bus.song_note  = NOTE_W'($urandom_range(0, 31));
            enable         = ($urandom_range(0, 63) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/note_source_arbiter.md
Name: note_source_arbiter

Overview:
- Shares the single tone generator (note index 0..21 feeding the pre-divider lookup) between two requesters: the song playback stream and the live piano keys.
- Paces song notes at one per tempo tick, which it generates internally.
- Live keys pre-empt the song immediately; after key release, a silent tail of TAIL_TICKS ticks runs before the song resumes.
- Sits between the song ROM shifter / key decoder and the tone divider.

Parameters:
- NOTE_W, 5, width of note index.
- MAX_NOTE, 21, highest legal note index; larger values are treated as rest.
- TICK_DIV, 6250000, clk cycles per tempo tick (8 Hz at 50 MHz).
- TAIL_TICKS, 4, silent ticks after key release before the song may resume (0 allowed).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- enable, input, 1, arbiter run enable.
- song_valid, input, 1, song note available.
- song_note, input, NOTE_W, song note index (0 = rest).
- song_ready, output, 1, song note accepted this cycle.
- key_valid, input, 1, a piano key is held.
- key_note, input, NOTE_W, held key note index.
- tone_note, output, NOTE_W, note index to tone divider.
- tone_on, output, 1, speaker gate.
- grant_key, output, 1, keys currently own the tone generator.
- tick_o, output, 1, one-cycle tempo tick pulse.
- state_o, output, 2, current state: IDLE=0, SONG=1, KEY=2, TAIL=3.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; tick counter=0; tail counter=0; tone_note=0; tone_on=0; grant_key=0; tick_o=0.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable=1.
  - tick_o=1 for the one cycle in which the counter equals TICK_DIV-1; the counter then wraps to 0.
  - Held at 0 while enable=0.
- song_ready (combinational) = enable & tick_o & ~key_valid & (state==IDLE or state==SONG).
- Transfer occurs when song_valid & song_ready.
- Sanitize rule: any note > MAX_NOTE becomes 0. tone_on is registered as (sanitized note != 0).
- IDLE:
  - tone_on=0.
  - key_valid=1 -> KEY next cycle (no tick wait).
  - Else on transfer -> SONG; tone_note <= sanitized song_note.
- SONG:
  - Each transfer updates tone_note/tone_on on the next edge.
  - Tick with song_valid=0 (underrun) -> IDLE, tone_on=0, tone_note=0.
  - key_valid=1 -> KEY next cycle, regardless of tick.
- KEY:
  - grant_key=1.
  - tone_note <= sanitized key_note every cycle; tone_on <= (sanitized key_note != 0).
  - One cycle latency from key_valid/key_note to outputs.
  - key_valid=0 -> TAIL with tail counter=TAIL_TICKS, tone_on=0. If TAIL_TICKS=0, go -> IDLE instead.
- TAIL:
  - grant_key=1, tone_on=0.
  - Tail counter decrements on each tick.
  - key_valid=1 -> KEY (tail abandoned).
  - Tick with tail counter==1 -> IDLE.
  - song_ready stays 0 for the whole TAIL.
- Simultaneous events:
  - key_valid and a song transfer opportunity in the same cycle: key wins; song_ready=0; no song note is consumed.
  - Tick and key release in the same cycle: TAIL is entered with the full count; that tick is not counted.
- enable=0:
  - Next edge forces IDLE; tone_on=0, tone_note=0, grant_key=0, tail counter=0.
  - song_ready=0 and tick_o=0.
- Reset mid-note: outputs clear immediately (asynchronous). The first tick after release comes TICK_DIV cycles after enable is sampled high.
- grant_key=0 in IDLE and SONG.

Optional Feature:
- Macro: ILLEGAL_NOTE_CNT_EN.
- Defined:
  - Adds output illegal_cnt[7:0], reset 0.
  - Increments by 1, saturating at 255, for each accepted song note or each KEY-state sample whose raw value > MAX_NOTE.
  - Clears when enable=0.
- Undefined: port and counter absent. Sanitizing is identical either way.

Test Plan:
- TICK_DIV=4, song_valid=1 with notes 8, 9, 10: song_ready pulses every 4th cycle, coincident with tick_o; tone_note steps 8 -> 9 -> 10 one cycle after each pulse; tone_on=1; state_o=1.
- During SONG, key_valid=1, key_note=15 arrives on a tick cycle: song_ready=0; next cycle state_o=2, grant_key=1, tone_note=15; the song note is not consumed.
- Release key with TAIL_TICKS=2: tone_on=0 immediately, state_o=3; two ticks later state_o=0; the next tick accepts a song note.
- Song note 27 and song note 0: tone_note=0, tone_on=0 in both cases. With ILLEGAL_NOTE_CNT_EN, illegal_cnt increments once for 27 and not for 0.
- Song underrun (song_valid=0 at a tick while in SONG): state_o=0, tone_on=0. Re-assert song_valid: accepted at the next tick.
- Assert rst_n low mid-KEY: all outputs 0 asynchronously. enable=0 pulse during TAIL: returns to IDLE; tick counter restarts at 0.
